// File: rtl/prbs8_checker_if.sv
// Receive-side bundle for the PRBS8 checker: serial bit stream in, lock/error status and display out.
interface prbs8_checker_if #(
    parameter int ERR_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_err;
    logic             locked;
    logic             sync_loss;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [6:0]       F1;
    logic [6:0]       F2;

    modport master (
        output bit_in, bit_valid, clear_err,
        input  locked, sync_loss, err_pulse, err_count, F1, F2
    );

    modport slave (
        input  bit_in, bit_valid, clear_err,
        output locked, sync_loss, err_pulse, err_count, F1, F2
    );
endinterface

// File: rtl/prbs8_checker.sv
// PRBS8 receiver: locks onto b[n+8] = b[n+4]^b[n+3]^b[n+2]^b[n], then counts bit errors
// against a free-running reference and shows the low error byte on two active-low hex digits.
module prbs8_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input logic           clk,
    input logic           reset,
    prbs8_checker_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_COUNT);
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_THRESH);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    state_t           state, state_n;
    logic [7:0]       r, r_n;
    logic [3:0]       fill, fill_n;
    logic [7:0]       match_cnt, match_n, match_inc;
    logic [3:0]       miss_run, miss_n, miss_inc;
    logic [ERR_W-1:0] err_count, err_n;
    logic             sync_loss, sync_loss_n;
    logic             err_pulse, err_pulse_n;
    logic [6:0]       f1, f2;
    logic             pred;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign pred      = r[4] ^ r[3] ^ r[2] ^ r[0];
    assign match_inc = match_cnt + 8'd1;
    assign miss_inc  = miss_run + 4'd1;

    always_comb begin
        state_n     = state;
        r_n         = r;
        fill_n      = fill;
        match_n     = match_cnt;
        miss_n      = miss_run;
        err_n       = err_count;
        sync_loss_n = 1'b0;
        err_pulse_n = 1'b0;
        if (bus.bit_valid) begin
            case (state)
                HUNT: begin
                    r_n = {bus.bit_in, r[7:1]};
                    if (fill != 4'd8) begin
                        fill_n = fill + 4'd1;
                    end else if (bus.bit_in == pred && r != 8'd0) begin
                        if (match_inc == LOCK_LIM) begin
                            state_n = LOCKED;
                            match_n = 8'd0;
                            miss_n  = 4'd0;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n = 8'd0;
                    end
                end
                default: begin
                    // Reference keeps running on its own prediction so a flipped bit costs one error.
                    r_n = {pred, r[7:1]};
                    if (bus.bit_in != pred) begin
                        err_pulse_n = 1'b1;
                        err_n       = sat_inc(err_count);
                        if (miss_inc == LOSS_LIM) begin
                            state_n     = HUNT;
                            fill_n      = 4'd0;
                            match_n     = 8'd0;
                            miss_n      = 4'd0;
                            sync_loss_n = 1'b1;
                        end else begin
                            miss_n = miss_inc;
                        end
                    end else begin
                        miss_n = 4'd0;
                    end
                end
            endcase
        end
        if (bus.clear_err) err_n = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            r         <= 8'd0;
            fill      <= 4'd0;
            match_cnt <= 8'd0;
            miss_run  <= 4'd0;
            err_count <= '0;
            sync_loss <= 1'b0;
            err_pulse <= 1'b0;
            f1        <= SEG_ZERO;
            f2        <= SEG_ZERO;
        end else begin
            state     <= state_n;
            r         <= r_n;
            fill      <= fill_n;
            match_cnt <= match_n;
            miss_run  <= miss_n;
            err_count <= err_n;
            sync_loss <= sync_loss_n;
            err_pulse <= err_pulse_n;
            // Display decodes the registered count, hence one cycle behind it.
            f1        <= hex_to_seg(err_count[7:4]);
            f2        <= hex_to_seg(err_count[3:0]);
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.sync_loss = sync_loss;
    assign bus.err_pulse = err_pulse;
    assign bus.err_count = err_count;
    assign bus.F1        = f1;
    assign bus.F2        = f2;
endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: default instance for lock/error/loss/gap behaviour,
// ERR_W=8 instance for counter saturation and clear priority.
module tb_prbs8_checker;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] s, s8;
    logic b;
    int   bad;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEGF = 7'b0001110;

    prbs8_checker_if #(.ERR_W(16)) bus ();
    prbs8_checker_if #(.ERR_W(8))  bus8 ();

    prbs8_checker #(.LOCK_COUNT(16), .LOSS_THRESH(4), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    prbs8_checker #(.LOCK_COUNT(16), .LOSS_THRESH(4), .ERR_W(8)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] adv(input logic [7:0] st);
        return {st[4] ^ st[3] ^ st[2] ^ st[0], st[7:1]};
    endfunction

    task automatic next_bit(output logic o);
        o = s[0];
        s = adv(s);
    endtask

    task automatic next_bit8(output logic o);
        o = s8[0];
        s8 = adv(s8);
    endtask

    task automatic drive(input logic bi, input logic v, input logic clr);
        @(negedge clk);
        bus.bit_in = bi; bus.bit_valid = v; bus.clear_err = clr;
        @(posedge clk); #1;
    endtask

    task automatic drive8(input logic bi, input logic v, input logic clr);
        @(negedge clk);
        bus8.bit_in = bi; bus8.bit_valid = v; bus8.clear_err = clr;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.bit_in = 1'b0;  bus.bit_valid = 1'b0;  bus.clear_err = 1'b0;
        bus8.bit_in = 1'b0; bus8.bit_valid = 1'b0; bus8.clear_err = 1'b0;

        // Reset with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            chk("rst_locked", bus.locked, 1'b0);
            chk("rst_pulses", {bus.sync_loss, bus.err_pulse}, 2'b00);
            chk("rst_err_count", bus.err_count, 16'd0);
            chk("rst_F1", bus.F1, SEG0);
            chk("rst_F2", bus.F2, SEG0);
        end
        reset = 1'b0;

        // Clean lock from seed 01, lock on 24th bit
        s = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            next_bit(b);
            drive(b, 1'b1, 1'b0);
            chk($sformatf("lock_bit%0d", i), bus.locked, (i == 24));
        end
        bad = 0;
        for (int i = 25; i <= 500; i++) begin
            next_bit(b);
            drive(b, 1'b1, 1'b0);
            if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b1) bad++;
        end
        chk("clean_run_glitches", bad, 0);
        chk("clean_err_count", bus.err_count, 16'd0);
        chk("clean_F1", bus.F1, SEG0);
        chk("clean_F2", bus.F2, SEG0);

        // Single flipped bit
        next_bit(b);
        drive(~b, 1'b1, 1'b0);
        chk("single_err_pulse", bus.err_pulse, 1'b1);
        chk("single_err_count", bus.err_count, 16'd1);
        chk("single_locked", bus.locked, 1'b1);
        chk("single_F2_latency", bus.F2, SEG0);
        next_bit(b);
        drive(b, 1'b1, 1'b0);
        chk("single_pulse_end", bus.err_pulse, 1'b0);
        chk("single_F2", bus.F2, SEG1);
        chk("single_F1", bus.F1, SEG0);
        chk("single_locked2", bus.locked, 1'b1);

        // Four consecutive flips cause loss of sync
        for (int k = 1; k <= 4; k++) begin
            next_bit(b);
            drive(~b, 1'b1, 1'b0);
            chk($sformatf("loss_sync_loss%0d", k), bus.sync_loss, (k == 4));
            chk($sformatf("loss_locked%0d", k), bus.locked, (k != 4));
            chk($sformatf("loss_err_pulse%0d", k), bus.err_pulse, 1'b1);
        end
        chk("loss_err_count", bus.err_count, 16'd5);

        // Relock after 24 clean bits; no counting while hunting
        for (int i = 1; i <= 24; i++) begin
            next_bit(b);
            drive(b, 1'b1, 1'b0);
            chk($sformatf("relock_bit%0d", i), bus.locked, (i == 24));
            if (i == 1) chk("relock_sync_loss_end", bus.sync_loss, 1'b0);
        end
        chk("relock_err_count", bus.err_count, 16'd5);
        chk("relock_F2", bus.F2, SEG5);
        chk("relock_F1", bus.F1, SEG0);

        // Invalid cycles change nothing
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0 || bus.err_count !== 16'd5) bad++;
        end
        chk("idle_no_change", bad, 0);

        // Mid-operation reset beats a valid error bit
        next_bit(b);
        @(negedge clk);
        reset = 1'b1;
        bus.bit_in = ~b; bus.bit_valid = 1'b1; bus.clear_err = 1'b0;
        @(posedge clk); #1;
        chk("midrst_locked", bus.locked, 1'b0);
        chk("midrst_err_count", bus.err_count, 16'd0);
        chk("midrst_err_pulse", bus.err_pulse, 1'b0);
        chk("midrst_F2", bus.F2, SEG0);
        reset = 1'b0;

        // All-zero stream never locks
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (bus.locked !== 1'b0) bad++;
        end
        chk("zero_never_locks", bad, 0);
        chk("zero_err_count", bus.err_count, 16'd0);

        // Seed A5 with a valid bit every third cycle
        @(negedge clk);
        reset = 1'b1; bus.bit_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        s = 8'hA5;
        for (int i = 1; i <= 24; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            next_bit(b);
            drive(b, 1'b1, 1'b0);
            chk($sformatf("gap_lock_bit%0d", i), bus.locked, (i == 24));
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_hold_locked", bus.locked, 1'b1);
        chk("gap_err_count", bus.err_count, 16'd0);

        // ERR_W=8 instance: saturation and clear priority
        s8 = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            next_bit8(b);
            drive8(b, 1'b1, 1'b0);
        end
        chk("w8_locked", bus8.locked, 1'b1);
        bad = 0;
        for (int e = 1; e <= 300; e++) begin
            next_bit8(b);
            drive8(~b, 1'b1, 1'b0);
            if (bus8.err_count !== ((e > 255) ? 8'hFF : 8'(e))) bad++;
            next_bit8(b);
            drive8(b, 1'b1, 1'b0);
        end
        chk("w8_count_track", bad, 0);
        chk("w8_saturated", bus8.err_count, 8'hFF);
        chk("w8_still_locked", bus8.locked, 1'b1);
        chk("w8_F1", bus8.F1, SEGF);
        chk("w8_F2", bus8.F2, SEGF);

        next_bit8(b);
        drive8(~b, 1'b1, 1'b1);
        chk("w8_clear_wins", bus8.err_count, 8'h00);
        next_bit8(b);
        drive8(~b, 1'b1, 1'b0);
        chk("w8_after_clear", bus8.err_count, 8'h01);
        chk("w8_after_clear_pulse", bus8.err_pulse, 1'b1);
        next_bit8(b);
        drive8(b, 1'b1, 1'b0);
        chk("w8_F2_one", bus8.F2, SEG1);
        chk("w8_F1_zero", bus8.F1, SEG0);
        chk("w8_locked_end", bus8.locked, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prbs8_checker.md
# prbs8_checker

Serial receiver/checker for the 8-bit LFSR pattern stream produced by the board's pseudo-random generator. It recovers the generator state from incoming bits and locks onto the sequence. Once locked, it counts bit errors and drives two active-low 7-segment digits with the low byte of the error count. It sits at the far end of a loopback or link under test.

## Interface
- LOCK_COUNT, 16, consecutive correct predictions required in HUNT before declaring lock (1..255)
- LOSS_THRESH, 4, consecutive mismatches in LOCKED that declare loss of sync (1..15)
- ERR_W, 16, width of the saturating error counter (>= 8)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bit_in  in  1  received serial data bit
- bit_valid  in  1  bit_in is sampled on this clock edge; gaps of any length are allowed
- clear_err  in  1  synchronous clear of err_count
- locked  out  1  high while in LOCKED
- sync_loss  out  1  one-cycle pulse on the LOCKED->HUNT transition
- err_pulse  out  1  one-cycle pulse per counted bit error
- err_count  out  ERR_W  saturating error count
- F1  out  7  active-low segments {g,f,e,d,c,b,a}, hex digit of err_count[7:4]
- F2  out  7  active-low segments, hex digit of err_count[3:0]

## Operation
- Stream definition: the generator state s advances as s' = {s[4]^s[3]^s[2]^s[0], s[7:1]} and transmits s[0] per step. Therefore b[n+8] = b[n+4]^b[n+3]^b[n+2]^b[n].
- History register r[7:0] shifts right with the new bit entering at r[7]. Prediction p = r[4]^r[3]^r[2]^r[0].
- Nothing changes on cycles with bit_valid=0, except clear_err and segment refresh.
- HUNT (state after reset):
  - The first 8 valid bits fill r; fill counter runs 0..8 with no compare.
  - Afterwards, every valid bit is compared with p and then shifted into r.
  - On a match with r != 0, match_cnt increments. On a mismatch, or when r == 0, match_cnt is cleared.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - Errors are never counted in HUNT. An all-zero stream never locks.
- LOCKED:
  - r shifts in p, not bit_in, so the reference runs freely and one flipped bit counts as exactly one error.
  - On a mismatch: err_pulse, err_count+1 (saturating at all-ones), miss_run+1.
  - On a match: miss_run cleared.
  - When miss_run reaches LOSS_THRESH, go to HUNT. This clears fill, match_cnt and miss_run and pulses sync_loss. The mismatch that triggers loss is still counted.
- clear_err sets err_count to 0. If an error occurs in the same cycle, the clear wins and err_count is 0.
- Segment encoding for digits 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.

## Timing
- All outputs are registered.
- Reset values:
  - locked, sync_loss, err_pulse = 0
  - err_count = 0
  - F1 = F2 = 7'b1000000
  - state HUNT; r, fill, match_cnt and miss_run all 0
- Reset asserted mid-operation takes effect on the next edge and overrides bit_valid and clear_err.
- locked rises on the edge that accepts the LOCK_COUNT-th matching bit. With defaults and a clean stream, that is the 24th valid bit.
- err_pulse and the err_count increment appear on the same edge that samples the erroneous bit.
- F1/F2 follow err_count with one extra cycle of latency.
- sync_loss and the falling edge of locked occur on the same edge as the LOSS_THRESH-th consecutive mismatch.

## Test plan
- Reset: hold reset 3 cycles with random bit_in/bit_valid -> locked=0, err_count=0, F1=F2=7'b1000000, and no pulses.
- Clean lock: stream from seed 8'h01 with bit_valid every cycle -> locked=1 after the 24th bit, err_count stays 0 for 500 bits, and F1=F2=1000000.
- Single error: when locked, invert one bit -> one err_pulse, err_count=1, F2=7'b1111001 one cycle later, locked stays 1.
- Loss and relock: invert 4 consecutive bits -> err_count increases by 4 and sync_loss pulses on the 4th bit. locked then falls and re-rises after 24 further clean bits.
- Zero stream and gaps: 200 zero bits -> locked stays 0. Seed 8'hA5 with bit_valid every 3rd cycle -> lock at the 24th valid bit.
- Counter edges: with ERR_W=8, 300 isolated errors -> err_count=8'hFF, F1=F2=7'b0001110. clear_err coincident with an error -> err_count=0.
